alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single 8-bit ALU between two requesters: port A is the core instruction path and port B is the auxiliary/debug path. The block arbitrates round-robin, registers the winning operands and mode, and drives the ALU enable for a fixed number of cycles. It then captures Out/CFlags/Flags and returns them to the owning requester over a valid/ready response handshake. It sits between the requesters and the ALU instance in the 8-bit MCU datapath.

Parameters:
ALU_LAT, 1, number of cycles E is held high per operation before the result is captured (1..15)
DW, 8, operand/result width; must match the ALU

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
a_req_valid  in  1  requester A operation request
a_req_ready  out  1  A request accepted this cycle
a_op1, a_op2  in  DW  A operands
a_mode  in  4  A ALU mode
a_rsp_valid  out  1  result available for A
a_rsp_ready  in  1  A consumes result
b_req_valid, b_req_ready, b_op1, b_op2, b_mode, b_rsp_valid, b_rsp_ready  same as A, for requester B
rsp_data  out  DW  captured ALU Out, shared by both responses
rsp_cflags  out  4  captured CFlags
rsp_flag  out  1  captured Flags
Operand1, Operand2  out  DW  to ALU
Mode  out  4  to ALU
E  out  1  ALU enable
Out  in  DW  from ALU
CFlags  in  4  from ALU
Flags  in  1  from ALU

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; all *_ready, *_rsp_valid and E = 0; Operand1/2, Mode, rsp_data, rsp_cflags, rsp_flag = 0; last_grant = B, so A wins the first tie; latency counter = 0. Reset mid-operation aborts the operation and discards any pending result.
- FSM states: IDLE, EXEC, RESP.
- IDLE: winner = the only valid requester; if both are valid, winner = the requester that is not last_grant. Only the winner's req_ready is driven high, combinationally, and only in IDLE. A loser's request stays pending and must be held stable by the requester. On valid&ready: latch op1/op2/mode into Operand1/Operand2/Mode, record the owner, go to EXEC with cnt=0. With no valid request, stay in IDLE.
- EXEC: E=1 every cycle. Operand1/2 and Mode stay stable from the registers. cnt increments each cycle. In the cycle where cnt==ALU_LAT-1, capture Out/CFlags/Flags into the rsp_* registers at the edge and go to RESP.
- RESP: E=0. The owner's rsp_valid=1; the other requester's rsp_valid=0. rsp_* stay stable until handshake. When the owner's rsp_ready=1, at that edge: last_grant=owner, go to IDLE. The next request can be accepted one cycle after the response handshake.
- Timing: request accepted at edge T; E high for cycles T+1..T+ALU_LAT; rsp_valid high from T+ALU_LAT+1. With ALU_LAT=1 and rsp_ready tied high, an operation takes 3 cycles.
- Operand1/2 and Mode retain their last values outside EXEC, with no X and no glitching.
- The non-owner's rsp_ready is ignored. The owner's rsp_ready asserted before rsp_valid has no effect.
- The block does not interpret mode; every 4-bit value is passed through unchanged.

Optional Feature:
ALU_ARB_STATS_EN: when defined, the block adds outputs a_grant_cnt and b_grant_cnt (16 bits each) and an input stats_clr (1 bit).
- Each counter increments on its requester's accepted request and saturates at 16'hFFFF.
- Both counters clear on reset or when stats_clr=1; clear wins over a simultaneous increment.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single A request with op1=12, op2=5, mode=0000, and rsp_ready held high: a_req_ready pulses 1 cycle; E high exactly 1 cycle; a_rsp_valid 2 cycles after acceptance; rsp_data = ALU model result (17); b_rsp_valid stays 0.
- A and B both valid from reset (A: 12,5,0001; B: 100,55,0000): A is served first; B is served next without deasserting; B's response = 155; a third simultaneous pair grants A again.
- Response backpressure: hold a_rsp_ready=0 for 5 cycles. a_rsp_valid and rsp_data stay stable, E=0, b_req_ready stays 0 throughout. B is accepted 1 cycle after the A response handshake.
- ALU_LAT=3: E high 3 consecutive cycles; the capture uses Out on the third cycle (change the ALU model output between cycles to prove it); rsp_valid arrives 4 cycles after acceptance.
- Drop rst_n low during EXEC: at the next edge E=0, state returns to IDLE, no rsp_valid appears, and the next tie is granted to A.
- With ALU_ARB_STATS_EN: 3 A grants and 2 B grants give counts 3 and 2; stats_clr asserted together with an accept leaves the count at 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one DW-bit ALU between requester A (core) and B (debug).
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters and stats_clr.
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned DW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          a_req_valid,
    output logic          a_req_ready,
    input  logic [DW-1:0] a_op1,
    input  logic [DW-1:0] a_op2,
    input  logic [3:0]    a_mode,
    output logic          a_rsp_valid,
    input  logic          a_rsp_ready,

    input  logic          b_req_valid,
    output logic          b_req_ready,
    input  logic [DW-1:0] b_op1,
    input  logic [DW-1:0] b_op2,
    input  logic [3:0]    b_mode,
    output logic          b_rsp_valid,
    input  logic          b_rsp_ready,

`ifdef ALU_ARB_STATS_EN
    input  logic          stats_clr,
    output logic [15:0]   a_grant_cnt,
    output logic [15:0]   b_grant_cnt,
`endif

    output logic [DW-1:0] rsp_data,
    output logic [3:0]    rsp_cflags,
    output logic          rsp_flag,

    output logic [DW-1:0] Operand1,
    output logic [DW-1:0] Operand2,
    output logic [3:0]    Mode,
    output logic          E,
    input  logic [DW-1:0] Out,
    input  logic [3:0]    CFlags,
    input  logic          Flags
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic {REQ_A, REQ_B} req_t;

    localparam logic [3:0] CNT_LAST = 4'(ALU_LAT - 1);

    state_t     state, state_nxt;
    req_t       owner, last_grant;
    logic [3:0] cnt;
    logic       a_win, b_win, rsp_done;

    // A wins when alone or when B was served last; B takes every other valid case.
    assign a_win = a_req_valid && (!b_req_valid || last_grant == REQ_B);
    assign b_win = b_req_valid && !a_win;

    // NOTE: reset is sampled only on the clock edge, so it sits inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_nxt   = state;
        a_req_ready = 1'b0;
        b_req_ready = 1'b0;
        a_rsp_valid = 1'b0;
        b_rsp_valid = 1'b0;
        E           = 1'b0;
        rsp_done    = 1'b0;
        case (state)
            IDLE: begin
                a_req_ready = a_win;
                b_req_ready = b_win;
                if (a_win || b_win) state_nxt = EXEC;
            end
            EXEC: begin
                E = 1'b1;
                if (cnt == CNT_LAST) state_nxt = RESP;
            end
            RESP: begin
                a_rsp_valid = (owner == REQ_A);
                b_rsp_valid = (owner == REQ_B);
                rsp_done    = (owner == REQ_A) ? a_rsp_ready : b_rsp_ready;
                if (rsp_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand/mode registers hold their last value outside EXEC so the ALU inputs never glitch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Operand1   <= '0;
            Operand2   <= '0;
            Mode       <= '0;
            rsp_data   <= '0;
            rsp_cflags <= '0;
            rsp_flag   <= 1'b0;
            cnt        <= '0;
            owner      <= REQ_A;
            last_grant <= REQ_B;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req_ready) begin
                        Operand1 <= a_op1;
                        Operand2 <= a_op2;
                        Mode     <= a_mode;
                        owner    <= REQ_A;
                        cnt      <= '0;
                    end else if (b_req_ready) begin
                        Operand1 <= b_op1;
                        Operand2 <= b_op2;
                        Mode     <= b_mode;
                        owner    <= REQ_B;
                        cnt      <= '0;
                    end
                end
                EXEC: begin
                    if (cnt == CNT_LAST) begin
                        rsp_data   <= Out;
                        rsp_cflags <= CFlags;
                        rsp_flag   <= Flags;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_done) last_grant <= owner;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Clear has priority over a same-cycle grant; counts stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            a_grant_cnt <= '0;
            b_grant_cnt <= '0;
        end else begin
            if (a_req_ready && a_grant_cnt != 16'hFFFF) a_grant_cnt <= a_grant_cnt + 16'd1;
            if (b_req_ready && b_grant_cnt != 16'hFFFF) b_grant_cnt <= b_grant_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: ALU_LAT=1 instance for arbitration/handshakes,
// ALU_LAT=3 instance for multi-cycle capture timing.
module tb_alu_arbiter;

    typedef struct {
        logic       who;
        logic [7:0] op1;
        logic [7:0] op2;
        logic [3:0] mode;
        logic [7:0] data;
        logic [3:0] cf;
        logic       fl;
    } exp_t;

    exp_t sb[$];
    logic grant_order[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] last_b_data;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ALU_LAT = 1 instance
    logic       a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [7:0] a_op1, a_op2;
    logic [3:0] a_mode;
    logic       b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [7:0] b_op1, b_op2;
    logic [3:0] b_mode;
    logic [7:0] rsp_data, Operand1, Operand2, Out;
    logic [3:0] rsp_cflags, Mode, CFlags;
    logic       rsp_flag, E, Flags;

    // ALU_LAT = 3 instance (B side idle)
    logic       l3_a_req_valid, l3_a_req_ready, l3_a_rsp_valid, l3_a_rsp_ready;
    logic [7:0] l3_a_op1, l3_a_op2;
    logic [3:0] l3_a_mode;
    logic       l3_b_req_valid, l3_b_req_ready, l3_b_rsp_valid, l3_b_rsp_ready;
    logic [7:0] l3_b_op1, l3_b_op2;
    logic [3:0] l3_b_mode;
    logic [7:0] l3_rsp_data, l3_Operand1, l3_Operand2, l3_Out;
    logic [3:0] l3_rsp_cflags, l3_Mode, l3_CFlags;
    logic       l3_rsp_flag, l3_E, l3_Flags;
    logic [12:0] l3_model;
    logic [7:0]  e_cnt3;

`ifdef ALU_ARB_STATS_EN
    logic        stats_clr, l3_stats_clr;
    logic [15:0] a_grant_cnt, b_grant_cnt, l3_a_grant_cnt, l3_b_grant_cnt;
`endif

    // Reference ALU: {flag, cflags[3:0], data[7:0]}; modes >= 4 fold the mode value in.
    function automatic logic [12:0] alu_model(input logic [7:0] x, input logic [7:0] y,
                                              input logic [3:0] m);
        logic [8:0] r;
        case (m)
            4'd0:    r = {1'b0, x} + {1'b0, y};
            4'd1:    r = {1'b0, x} - {1'b0, y};
            4'd2:    r = {1'b0, x & y};
            4'd3:    r = {1'b0, x | y};
            default: r = {1'b0, x ^ y ^ {4'h0, m}};
        endcase
        return {r[7:0] == 8'h00, r[8], r[7], ^r[7:0], m[0], r[7:0]};
    endfunction

    function automatic exp_t mk(input logic who, input logic [7:0] x, input logic [7:0] y,
                                input logic [3:0] m);
        exp_t       e;
        logic [12:0] r;
        r      = alu_model(x, y, m);
        e.who  = who;
        e.op1  = x;
        e.op2  = y;
        e.mode = m;
        e.data = r[7:0];
        e.cf   = r[11:8];
        e.fl   = r[12];
        return e;
    endfunction

    assign {Flags, CFlags, Out} = alu_model(Operand1, Operand2, Mode);

    // Second ALU output drifts by the number of E-high cycles already elapsed.
    assign l3_model  = alu_model(l3_Operand1, l3_Operand2, l3_Mode);
    assign l3_Out    = l3_model[7:0] + e_cnt3;
    assign l3_CFlags = l3_model[11:8];
    assign l3_Flags  = l3_model[12];
    always @(posedge clk) e_cnt3 <= l3_E ? e_cnt3 + 8'd1 : 8'd0;

    alu_arbiter #(.ALU_LAT(1), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_op1(a_op1), .a_op2(a_op2),
        .a_mode(a_mode), .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_op1(b_op1), .b_op2(b_op2),
        .b_mode(b_mode), .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
`ifdef ALU_ARB_STATS_EN
        .stats_clr(stats_clr), .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt),
`endif
        .rsp_data(rsp_data), .rsp_cflags(rsp_cflags), .rsp_flag(rsp_flag),
        .Operand1(Operand1), .Operand2(Operand2), .Mode(Mode), .E(E),
        .Out(Out), .CFlags(CFlags), .Flags(Flags)
    );

    alu_arbiter #(.ALU_LAT(3), .DW(8)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(l3_a_req_valid), .a_req_ready(l3_a_req_ready), .a_op1(l3_a_op1),
        .a_op2(l3_a_op2), .a_mode(l3_a_mode), .a_rsp_valid(l3_a_rsp_valid),
        .a_rsp_ready(l3_a_rsp_ready),
        .b_req_valid(l3_b_req_valid), .b_req_ready(l3_b_req_ready), .b_op1(l3_b_op1),
        .b_op2(l3_b_op2), .b_mode(l3_b_mode), .b_rsp_valid(l3_b_rsp_valid),
        .b_rsp_ready(l3_b_rsp_ready),
`ifdef ALU_ARB_STATS_EN
        .stats_clr(l3_stats_clr), .a_grant_cnt(l3_a_grant_cnt), .b_grant_cnt(l3_b_grant_cnt),
`endif
        .rsp_data(l3_rsp_data), .rsp_cflags(l3_rsp_cflags), .rsp_flag(l3_rsp_flag),
        .Operand1(l3_Operand1), .Operand2(l3_Operand2), .Mode(l3_Mode), .E(l3_E),
        .Out(l3_Out), .CFlags(l3_CFlags), .Flags(l3_Flags)
    );

    // Drives pending requests to completion, pushing on accept and popping on response.
    task automatic sb_run(input int budget);
        exp_t e;
        logic a_acc, b_acc;
        int   n;
        n = 0;
        while ((a_req_valid || b_req_valid || sb.size() != 0) && n < budget) begin
            #1;
            a_acc = a_req_valid && a_req_ready;
            b_acc = b_req_valid && b_req_ready;
            checks++;
            if (a_req_ready && b_req_ready) begin
                errors++; $display("FAIL sb_ready_excl both readies high at %0t", $time);
            end
            if (a_acc) begin sb.push_back(mk(1'b0, a_op1, a_op2, a_mode)); grant_order.push_back(1'b0); end
            if (b_acc) begin sb.push_back(mk(1'b1, b_op1, b_op2, b_mode)); grant_order.push_back(1'b1); end
            if (E && sb.size() != 0) begin
                checks++;
                if ({Operand1, Operand2, Mode} !== {sb[0].op1, sb[0].op2, sb[0].mode}) begin
                    errors++;
                    $display("FAIL sb_alu_inputs got %h/%h/%h want %h/%h/%h", Operand1, Operand2, Mode,
                             sb[0].op1, sb[0].op2, sb[0].mode);
                end
            end
            if (a_rsp_valid || b_rsp_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL sb_unexpected_rsp a=%b b=%b", a_rsp_valid, b_rsp_valid);
                end else begin
                    e = sb[0];
                    checks++;
                    if ((a_rsp_valid && b_rsp_valid) || (b_rsp_valid !== e.who)) begin
                        errors++;
                        $display("FAIL sb_rsp_owner got a=%b b=%b want owner %b", a_rsp_valid, b_rsp_valid, e.who);
                    end
                    if (e.who ? b_rsp_ready : a_rsp_ready) begin
                        checks++;
                        if ({rsp_flag, rsp_cflags, rsp_data} !== {e.fl, e.cf, e.data}) begin
                            errors++;
                            $display("FAIL sb_rsp_data got %b/%h/%h want %b/%h/%h", rsp_flag, rsp_cflags,
                                     rsp_data, e.fl, e.cf, e.data);
                        end
                        if (e.who) last_b_data = rsp_data;
                        void'(sb.pop_front());
                    end
                end
            end
            @(negedge clk);
            if (a_acc) a_req_valid = 1'b0;
            if (b_acc) b_req_valid = 1'b0;
            n++;
        end
        checks++;
        if (a_req_valid || b_req_valid || sb.size() != 0) begin
            errors++; $display("FAIL sb_timeout pending=%0d after %0d cycles", sb.size(), n);
            sb.delete();
            a_req_valid = 1'b0;
            b_req_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_req_valid = 1'b0; b_req_valid = 1'b0; l3_a_req_valid = 1'b0;
`ifdef ALU_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        grant_order.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (E !== 1'b0 || l3_E !== 1'b0) begin errors++; $display("FAIL reset_e got %b/%b want 0", E, l3_E); end
        checks++; if ({a_req_ready, b_req_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {a_req_ready, b_req_ready}); end
        checks++; if ({a_rsp_valid, b_rsp_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", {a_rsp_valid, b_rsp_valid}); end
        checks++; if ({Operand1, Operand2, Mode} !== 20'h0) begin errors++; $display("FAIL reset_operands got %h want 0", {Operand1, Operand2, Mode}); end
        checks++; if ({rsp_data, rsp_cflags, rsp_flag} !== 13'h0) begin errors++; $display("FAIL reset_rsp got %h want 0", {rsp_data, rsp_cflags, rsp_flag}); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_a();
        exp_t e;
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        @(negedge clk);
        a_op1 = 8'd12; a_op2 = 8'd5; a_mode = 4'b0000; a_req_valid = 1'b1;
        #1;
        checks++; if ({a_req_ready, b_req_ready} !== 2'b10) begin errors++; $display("FAIL single_accept got %b want 10", {a_req_ready, b_req_ready}); end
        e = mk(1'b0, 8'd12, 8'd5, 4'b0000);
        @(negedge clk);
        a_req_valid = 1'b0;
        #1;
        checks++; if ({a_req_ready, E, a_rsp_valid} !== 3'b010) begin errors++; $display("FAIL single_exec got rdy/E/rv=%b want 010", {a_req_ready, E, a_rsp_valid}); end
        checks++; if ({Operand1, Operand2, Mode} !== {8'd12, 8'd5, 4'd0}) begin errors++; $display("FAIL single_alu_in got %h want 0c050", {Operand1, Operand2, Mode}); end
        @(negedge clk); #1;
        checks++; if ({E, a_rsp_valid, b_rsp_valid} !== 3'b010) begin errors++; $display("FAIL single_resp got E/av/bv=%b want 010", {E, a_rsp_valid, b_rsp_valid}); end
        checks++; if (rsp_data !== 8'd17) begin errors++; $display("FAIL single_data got %0d want 17", rsp_data); end
        checks++; if ({rsp_flag, rsp_cflags} !== {e.fl, e.cf}) begin errors++; $display("FAIL single_flags got %b/%h want %b/%h", rsp_flag, rsp_cflags, e.fl, e.cf); end
        @(negedge clk); #1;
        checks++; if ({E, a_rsp_valid, b_rsp_valid} !== 3'b000) begin errors++; $display("FAIL single_done got E/av/bv=%b want 000", {E, a_rsp_valid, b_rsp_valid}); end
    endtask

    task automatic test_tie();
        do_reset();
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        a_op1 = 8'd12;  a_op2 = 8'd5;  a_mode = 4'b0001; a_req_valid = 1'b1;
        b_op1 = 8'd100; b_op2 = 8'd55; b_mode = 4'b0000; b_req_valid = 1'b1;
        sb_run(40);
        checks++; if (last_b_data !== 8'd155) begin errors++; $display("FAIL tie_b_data got %0d want 155", last_b_data); end
        a_op1 = 8'd7;   a_op2 = 8'd9;   a_mode = 4'h6; a_req_valid = 1'b1;
        b_op1 = 8'd200; b_op2 = 8'd100; b_mode = 4'h0; b_req_valid = 1'b1;
        sb_run(40);
        checks++;
        if (grant_order.size() != 4) begin
            errors++; $display("FAIL tie_order_len got %0d want 4", grant_order.size());
        end else if ({grant_order[0], grant_order[1], grant_order[2], grant_order[3]} !== 4'b0101) begin
            errors++;
            $display("FAIL tie_order got %b%b%b%b want 0101", grant_order[0], grant_order[1], grant_order[2], grant_order[3]);
        end
    endtask

    task automatic test_backpressure();
        a_rsp_ready = 1'b0; b_rsp_ready = 1'b1;
        @(negedge clk);
        a_op1 = 8'd33; a_op2 = 8'd44; a_mode = 4'd2; a_req_valid = 1'b1;
        #1;
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL bp_accept got %b want 1", a_req_ready); end
        sb.push_back(mk(1'b0, 8'd33, 8'd44, 4'd2));
        @(negedge clk);
        a_req_valid = 1'b0;
        b_op1 = 8'd9; b_op2 = 8'd3; b_mode = 4'd1; b_req_valid = 1'b1;
        #1;
        checks++; if (b_req_ready !== 1'b0) begin errors++; $display("FAIL bp_b_exec got %b want 0", b_req_ready); end
        @(negedge clk); #1;
        checks++; if (a_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid got %b want 1", a_rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({a_rsp_valid, E, b_req_ready, b_rsp_valid, rsp_data} !== {4'b1000, sb[0].data}) begin
                errors++;
                $display("FAIL bp_hold%0d got av/E/br/bv=%b data=%h want 1000 data=%h", i,
                         {a_rsp_valid, E, b_req_ready, b_rsp_valid}, rsp_data, sb[0].data);
            end
        end
        @(negedge clk);
        a_rsp_ready = 1'b1;
        #1;
        checks++;
        if ({a_rsp_valid, b_req_ready, rsp_flag, rsp_cflags, rsp_data} !== {2'b10, sb[0].fl, sb[0].cf, sb[0].data}) begin
            errors++; $display("FAIL bp_handshake got av/br=%b rsp=%h want 10 rsp=%h", {a_rsp_valid, b_req_ready},
                               {rsp_flag, rsp_cflags, rsp_data}, {sb[0].fl, sb[0].cf, sb[0].data});
        end
        void'(sb.pop_front());
        @(negedge clk); #1;
        checks++; if ({a_rsp_valid, b_req_ready} !== 2'b01) begin errors++; $display("FAIL bp_b_next got av/br=%b want 01", {a_rsp_valid, b_req_ready}); end
        sb_run(20);
    endtask

    task automatic test_lat3();
        exp_t e;
        int   e_cycles;
        int   first_rsp;
        e_cycles = 0; first_rsp = -1;
        l3_a_rsp_ready = 1'b1;
        @(negedge clk);
        l3_a_op1 = 8'd200; l3_a_op2 = 8'd100; l3_a_mode = 4'd0; l3_a_req_valid = 1'b1;
        #1;
        checks++; if (l3_a_req_ready !== 1'b1) begin errors++; $display("FAIL lat3_accept got %b want 1", l3_a_req_ready); end
        e = mk(1'b0, 8'd200, 8'd100, 4'd0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) l3_a_req_valid = 1'b0;
            #1;
            if (l3_E) e_cycles++;
            if (l3_a_rsp_valid && first_rsp < 0) begin
                first_rsp = c;
                checks++;
                if ({l3_rsp_flag, l3_rsp_cflags, l3_rsp_data} !== {e.fl, e.cf, e.data + 8'd2}) begin
                    errors++; $display("FAIL lat3_capture got %h want %h", {l3_rsp_flag, l3_rsp_cflags, l3_rsp_data},
                                       {e.fl, e.cf, e.data + 8'd2});
                end
            end
        end
        checks++; if (e_cycles != 3) begin errors++; $display("FAIL lat3_e_cycles got %0d want 3", e_cycles); end
        checks++; if (first_rsp != 4) begin errors++; $display("FAIL lat3_rsp_cycle got %0d want 4", first_rsp); end
    endtask

    task automatic test_reset_mid_exec();
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        a_op1 = 8'd1; a_op2 = 8'd2; a_mode = 4'd0; a_req_valid = 1'b1;
        sb_run(20);
        a_op1 = 8'd50; a_op2 = 8'd60; a_mode = 4'd3; a_req_valid = 1'b1;
        #1;
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_accept got %b want 1", a_req_ready); end
        @(negedge clk);
        a_req_valid = 1'b0;
        #1;
        checks++; if (E !== 1'b1) begin errors++; $display("FAIL rst_mid_exec got E=%b want 1", E); end
        rst_n = 1'b0;
        @(negedge clk); #1;
        checks++; if ({E, a_rsp_valid, Operand1, Operand2, Mode} !== 22'h0) begin
            errors++; $display("FAIL rst_mid_abort got E=%b av=%b ops=%h want 0", E, a_rsp_valid, {Operand1, Operand2, Mode});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if ({E, a_rsp_valid, b_rsp_valid} !== 3'b000) begin errors++; $display("FAIL rst_mid_quiet%0d got %b want 000", i, {E, a_rsp_valid, b_rsp_valid}); end
        end
        grant_order.delete();
        a_op1 = 8'd3; a_op2 = 8'd4; a_mode = 4'd0; a_req_valid = 1'b1;
        b_op1 = 8'd5; b_op2 = 8'd6; b_mode = 4'd1; b_req_valid = 1'b1;
        #1;
        checks++; if ({a_req_ready, b_req_ready} !== 2'b10) begin errors++; $display("FAIL rst_mid_tie got %b want 10", {a_req_ready, b_req_ready}); end
        sb_run(40);
    endtask

    task automatic test_back_to_back();
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_op1 = 8'($urandom); a_op2 = 8'($urandom); a_mode = 4'($urandom_range(15));
            b_op1 = 8'($urandom); b_op2 = 8'($urandom); b_mode = 4'($urandom_range(15));
            a_req_valid = 1'b1;
            b_req_valid = (i % 3 != 2);
            sb_run(40);
        end
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        #1;
        checks++; if ({a_grant_cnt, b_grant_cnt} !== 32'h0) begin errors++; $display("FAIL stats_reset got %h/%h want 0", a_grant_cnt, b_grant_cnt); end
        for (int i = 0; i < 5; i++) begin
            a_op1 = 8'(i); a_op2 = 8'd1; a_mode = 4'd0; b_op1 = 8'(i); b_op2 = 8'd2; b_mode = 4'd1;
            if (i < 3) a_req_valid = 1'b1;
            else       b_req_valid = 1'b1;
            sb_run(20);
        end
        checks++; if ({a_grant_cnt, b_grant_cnt} !== {16'd3, 16'd2}) begin errors++; $display("FAIL stats_counts got %0d/%0d want 3/2", a_grant_cnt, b_grant_cnt); end
        a_op1 = 8'd8; a_op2 = 8'd8; a_mode = 4'd0; a_req_valid = 1'b1; stats_clr = 1'b1;
        #1;
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL stats_clr_accept got %b want 1", a_req_ready); end
        sb.push_back(mk(1'b0, 8'd8, 8'd8, 4'd0));
        @(negedge clk);
        a_req_valid = 1'b0; stats_clr = 1'b0;
        #1;
        checks++; if ({a_grant_cnt, b_grant_cnt} !== 32'h0) begin errors++; $display("FAIL stats_clr_wins got %0d/%0d want 0/0", a_grant_cnt, b_grant_cnt); end
        sb_run(20);
        a_req_valid = 1'b1;
        sb_run(20);
        checks++; if (a_grant_cnt !== 16'd1) begin errors++; $display("FAIL stats_after_clr got %0d want 1", a_grant_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_req_valid = 1'b0; a_op1 = '0; a_op2 = '0; a_mode = '0; a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_op1 = '0; b_op2 = '0; b_mode = '0; b_rsp_ready = 1'b0;
        l3_a_req_valid = 1'b0; l3_a_op1 = '0; l3_a_op2 = '0; l3_a_mode = '0; l3_a_rsp_ready = 1'b0;
        l3_b_req_valid = 1'b0; l3_b_op1 = '0; l3_b_op2 = '0; l3_b_mode = '0; l3_b_rsp_ready = 1'b0;
        last_b_data = '0;
`ifdef ALU_ARB_STATS_EN
        stats_clr = 1'b0; l3_stats_clr = 1'b0;
`endif
        test_reset();
        test_single_a();
        test_tie();
        test_backpressure();
        test_lat3();
        test_reset_mid_exec();
        test_back_to_back();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
